// File: rtl/inta_sequencer_if.sv
// INTA sequencer bus bundle.
// Master drives requests and strobes; slave returns vector and ISR.
interface inta_sequencer_if;
  logic       INTA_n;
  logic [7:0] IRR;
  logic [4:0] ICW2_T;
  logic       AEOI;
  logic       EOI_Cmd;
  logic       EOI_Specific;
  logic [2:0] EOI_Level;
  logic       Address_Write_Enable;
  logic       INT;
  logic [2:0] Interrupt_Location;
  logic [7:0] ISR;
  logic [7:0] Clear_IRR;
  logic [7:0] Data_Out;
  logic       Data_Out_Enable;

  modport master (
    output INTA_n, IRR, ICW2_T, AEOI,
    output EOI_Cmd, EOI_Specific, EOI_Level,
    output Address_Write_Enable,
    input  INT, Interrupt_Location, ISR,
    input  Clear_IRR, Data_Out, Data_Out_Enable
  );

  modport slave (
    input  INTA_n, IRR, ICW2_T, AEOI,
    input  EOI_Cmd, EOI_Specific, EOI_Level,
    input  Address_Write_Enable,
    output INT, Interrupt_Location, ISR,
    output Clear_IRR, Data_Out, Data_Out_Enable
  );
endinterface

// File: rtl/inta_sequencer.sv
// Two-pulse INTA acknowledge sequencer for an 8259-style PIC.
// Freezes the winning IR, tracks in-service bits, drives the vector.
module inta_sequencer (
  input logic             CLK,
  input logic             RESET,
  inta_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       inta_prev;
  logic       fall;
  logic       rise;
  logic       spurious;
  logic       int_q;
  logic [2:0] loc_q;
  logic [7:0] isr_q;
  logic [7:0] clr_q;
  logic [7:0] dout_q;
  logic       doe_q;

  logic [7:0] qual;
  logic       qual_hit;
  logic [2:0] qual_idx;
  logic [7:0] set_mask;
  logic [7:0] eoi_mask;
  logic [7:0] aeoi_mask;
  logic [7:0] isr_nx;
  logic       int_nx;

  // Isolate the lowest set bit.
  function automatic logic [7:0] low_bit(
    input logic [7:0] v
  );
    return v & (~v + 8'd1);
  endfunction

  // Bits strictly higher in priority than the top in-service bit.
  function automatic logic [7:0] below(
    input logic [7:0] v
  );
    if (v == 8'd0)
      return 8'hFF;
    return low_bit(v) - 8'd1;
  endfunction

  // One-hot to index.
  function automatic logic [2:0] enc(
    input logic [7:0] v
  );
    logic [2:0] idx;
    idx = 3'd0;
    unique case (1'b1)
      v[0]:    idx = 3'd0;
      v[1]:    idx = 3'd1;
      v[2]:    idx = 3'd2;
      v[3]:    idx = 3'd3;
      v[4]:    idx = 3'd4;
      v[5]:    idx = 3'd5;
      v[6]:    idx = 3'd6;
      v[7]:    idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  // Strobe edges against the registered history.
  always_comb begin
    fall = inta_prev & ~bus.INTA_n;
    rise = ~inta_prev & bus.INTA_n;
  end

  // Winning request: lowest IRR bit above the in-service level.
  always_comb begin
    qual     = bus.IRR & below(isr_q);
    qual_hit = |qual;
    qual_idx = enc(low_bit(qual));
  end

  // Acknowledge phase progression.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fall) state_nx = ACK1;
      ACK1:    if (rise) state_nx = GAP;
      GAP:     if (fall) state_nx = ACK2;
      ACK2:    if (rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ISR update: clears first, then a new set wins on overlap.
  always_comb begin
    set_mask  = 8'd0;
    eoi_mask  = 8'd0;
    aeoi_mask = 8'd0;
    if (state == IDLE && fall && qual_hit)
      set_mask = 8'd1 << qual_idx;
    if (bus.EOI_Cmd) begin
      if (bus.EOI_Specific)
        eoi_mask = 8'd1 << bus.EOI_Level;
      else
        eoi_mask = low_bit(isr_q);
    end
    if (state == ACK2 && rise &&
        bus.AEOI && !spurious)
      aeoi_mask = 8'd1 << loc_q;
    isr_nx = (isr_q & ~(eoi_mask | aeoi_mask))
           | set_mask;
    int_nx = (state_nx == IDLE) &&
             |(bus.IRR & below(isr_nx));
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      inta_prev <= 1'b1;
      spurious  <= 1'b0;
      int_q     <= 1'b0;
      loc_q     <= 3'd0;
      isr_q     <= 8'd0;
      clr_q     <= 8'd0;
      dout_q    <= 8'd0;
      doe_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      inta_prev <= bus.INTA_n;
      isr_q     <= isr_nx;
      int_q     <= int_nx;
      clr_q     <= set_mask;
      if (state == IDLE && fall) begin
        spurious <= ~qual_hit;
        loc_q    <= qual_hit ? qual_idx : 3'd7;
      end
      if (state_nx == ACK2) begin
        dout_q <= {bus.ICW2_T, loc_q};
        doe_q  <= bus.Address_Write_Enable;
      end else begin
        doe_q  <= 1'b0;
      end
    end
  end

  assign bus.INT                = int_q;
  assign bus.Interrupt_Location = loc_q;
  assign bus.ISR                = isr_q;
  assign bus.Clear_IRR          = clr_q;
  assign bus.Data_Out           = dout_q;
  assign bus.Data_Out_Enable    = doe_q;

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port INTA_n, input, 1 bit: acknowledge strobe, active-low, already synchronous to CLK.
REQ-004 SHALL have port IRR, input, 8 bits: masked pending requests; bit 0 is the highest priority.
REQ-005 SHALL have port ICW2_T, input, 5 bits: vector base T7..T3.
REQ-006 SHALL have port AEOI, input, 1 bit: automatic end-of-interrupt enable.
REQ-007 SHALL have port EOI_Cmd, input, 1 bit: one-cycle end-of-interrupt command strobe.
REQ-008 SHALL have port EOI_Specific, input, 1 bit: 1 selects specific EOI, 0 selects non-specific EOI.
REQ-009 SHALL have port EOI_Level, input, 3 bits: ISR bit cleared by a specific EOI.
REQ-010 SHALL have port Address_Write_Enable, input, 1 bit: vector-drive permission from the cascade stage.
REQ-011 SHALL have port INT, output, 1 bit: interrupt request to the CPU.
REQ-012 SHALL have port Interrupt_Location, output, 3 bits: frozen IR number, fed to the cascade stage.
REQ-013 SHALL have port ISR, output, 8 bits: in-service register.
REQ-014 SHALL have port Clear_IRR, output, 8 bits: one-hot, one-cycle pulse that clears the acknowledged request.
REQ-015 SHALL have port Data_Out, output, 8 bits: interrupt vector.
REQ-016 SHALL have port Data_Out_Enable, output, 1 bit: data-bus drive enable.

Function
REQ-017 SHALL register INTA_n each cycle; a falling edge is prev=1 and now=0, and a rising edge is prev=0 and now=1.
REQ-018 SHALL implement the states IDLE, ACK1, GAP, ACK2.
- IDLE -> ACK1 on a falling edge.
- ACK1 -> GAP on a rising edge.
- GAP -> ACK2 on a falling edge.
- ACK2 -> IDLE on a rising edge.
REQ-019 SHALL define the qualifying request as the lowest-index set IRR bit whose index is below the lowest-index set ISR bit (any bit qualifies if ISR=0).
REQ-020 SHALL register INT as (state==IDLE) and (a qualifying request exists); INT falls the cycle after the first falling edge is detected.
REQ-021 SHALL, on the first falling edge with a qualifying request at index n:
- load Interrupt_Location=n;
- set ISR[n];
- pulse Clear_IRR[n] for exactly one cycle.
All three are visible the next cycle.
REQ-022 SHALL, on the first falling edge with no qualifying request (spurious), load Interrupt_Location=7, leave ISR unchanged and keep Clear_IRR=0.
REQ-023 SHALL hold Interrupt_Location constant from ACK1 through the end of ACK2.
REQ-024 SHALL keep Data_Out_Enable=0 during ACK1 and GAP.
REQ-025 SHALL, in ACK2, set Data_Out={ICW2_T, Interrupt_Location} and Data_Out_Enable=Address_Write_Enable, sampled every cycle.
REQ-026 SHALL deassert Data_Out_Enable the cycle after the second rising edge is detected.
REQ-027 SHALL, when AEOI=1 on the second rising edge of a non-spurious acknowledge, clear ISR[Interrupt_Location].
REQ-028 SHALL, on an EOI_Cmd pulse:
- with EOI_Specific=1, clear ISR[EOI_Level];
- with EOI_Specific=0, clear the lowest-index set ISR bit;
- with ISR=0, have no effect.
REQ-029 SHALL apply an EOI and an ISR set on the same cycle as clear-then-set; if both target the same bit, the set wins.
REQ-030 SHALL ignore IRR changes after ACK1 entry until the sequence completes.
REQ-031 SHALL register all outputs.

Reset
REQ-032 SHALL, while RESET=1, force: state=IDLE, INT=0, Interrupt_Location=0, ISR=0, Clear_IRR=0, Data_Out=0, Data_Out_Enable=0, INTA_n history=1.
REQ-033 SHALL abort any sequence in progress when RESET asserts and restart in IDLE; it SHALL NOT set or clear ISR bits for the aborted sequence.

Verification
REQ-034 Bench SHALL cover: IRR=0x28, ICW2_T=5'b01000, AWE=1, AEOI=0, two INTA pulses -> ISR=0x08, Clear_IRR=0x08 for one cycle, Data_Out=0x43 with enable in ACK2 only, INT low until IDLE.
REQ-035 Bench SHALL cover: ISR=0x04, IRR=0x10 -> INT=0; then a non-specific EOI -> ISR=0, and INT rises within 1 cycle.
REQ-036 Bench SHALL cover: IRR=0x00 at the first INTA (spurious) -> Interrupt_Location=7, ISR unchanged, Data_Out={ICW2_T,3'b111}.
REQ-037 Bench SHALL cover: AEOI=1, IRR=0x01 -> ISR[0] set after ACK1 and cleared the cycle after the second rising edge.
REQ-038 Bench SHALL cover: Address_Write_Enable=0 throughout ACK2 -> Data_Out_Enable stays 0 while ISR still updates.
REQ-039 Bench SHALL cover: RESET asserted during GAP -> all outputs at reset values next cycle; a fresh sequence then completes normally.
